// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FIFO controller for an external two-port RAM.
// Port 0 is the write port, port 1 the level-sensitive read port. Read data
// is captured one clock after an accepted read.
// Optional build macro: FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
// DEPTH may be any value from 2 to 2**ADDR_WIDTH; pointers wrap at DEPTH-1.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] ram_addr_0,
  output logic [DATA_WIDTH-1:0] ram_data_0,
  output logic                  ram_cs_0,
  output logic                  ram_we_0,
  output logic                  ram_oe_0,
  output logic [ADDR_WIDTH-1:0] ram_addr_1,
  input  logic [DATA_WIDTH-1:0] ram_data_1,
  output logic                  ram_cs_1,
  output logic                  ram_we_1,
  output logic                  ram_oe_1
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CW-1:0]         DEPTH_CNT = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_acc;
  logic [CW-1:0]         count_nxt;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  vld_p1;

  // Pointer advance with wrap at the last configured word, not at 2**ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    if (p == LAST_PTR) return '0;
    return p + ADDR_WIDTH'(1);
  endfunction

  // Accept decisions use the registered flags; reset and flush block both ports.
  always_comb begin
    wr_ack = rst_n & wr_req & ~full & ~flush;
    rd_acc = rst_n & rd_req & ~empty & ~flush;
  end

  // RAM strobes: the read strobe is pulsed on every accepted read so the
  // level-sensitive RAM re-evaluates even if the address has not moved.
  always_comb begin
    ram_addr_0 = wr_ptr;
    ram_data_0 = wr_data;
    ram_cs_0   = wr_ack;
    ram_we_0   = wr_ack;
    ram_oe_0   = 1'b0;
    ram_addr_1 = rd_ptr;
    ram_cs_1   = rd_acc;
    ram_we_1   = 1'b0;
    ram_oe_1   = rd_acc;
  end

  // Occupancy moves only when exactly one side transfers.
  always_comb begin
    count_nxt = count;
    case ({wr_ack, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy and flags; full/empty are derived from the next count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ack) wr_ptr <= next_ptr(wr_ptr);
      if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_CNT);
      empty <= (count_nxt == '0);
    end
  end

  // Read capture stage: word sampled from the RAM read port at the accept edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) rd_data_p1 <= ram_data_1;
    end
  end

  assign rd_data  = rd_data_p1;
  assign rd_valid = vld_p1;

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags: set by requests against a full/empty FIFO, cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_req && full)  overflow  <= 1'b1;
      if (rd_req && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: two fifo_ctrl instances (DEPTH 16 and DEPTH 12) driven by the
// same stimulus, each with its own RAM model and queue-based reference model.
module tb_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        wr_req = 1'b0;
  logic [15:0] wr_data = '0;
  logic        rd_req = 1'b0;

  logic        wr_ack_o [2];
  logic [15:0] rd_data_o [2];
  logic        rd_valid_o [2];
  logic        full_o [2];
  logic        empty_o [2];
  logic [4:0]  count_o [2];
  logic [3:0]  addr0_o [2];
  logic [15:0] data0_o [2];
  logic        cs0_o [2], we0_o [2], oe0_o [2];
  logic [3:0]  addr1_o [2];
  logic [15:0] data1_i [2];
  logic        cs1_o [2], we1_o [2], oe1_o [2];
  logic        ovf_o [2], unf_o [2];

  logic [15:0] mem [2][16];

  int          tests = 0;
  int          failed = 0;
  int          primed = 0;

  // Reference model state
  int          dep [2] = '{16, 12};
  logic [15:0] mq [2][$];
  int          wp [2];
  int          rp [2];
  logic        rdv [2];
  logic [15:0] rdd [2];
  logic        ovf [2];
  logic        unf [2];

  always #5 clk = ~clk;

  fifo_ctrl #(.ADDR_WIDTH(4), .DEPTH(16), .DATA_WIDTH(16)) u16 (
`ifdef FIFO_ERR_FLAGS_EN
    .overflow(ovf_o[0]), .underflow(unf_o[0]),
`endif
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_req(wr_req), .wr_data(wr_data),
    .wr_ack(wr_ack_o[0]), .rd_req(rd_req), .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]),
    .full(full_o[0]), .empty(empty_o[0]), .count(count_o[0]),
    .ram_addr_0(addr0_o[0]), .ram_data_0(data0_o[0]), .ram_cs_0(cs0_o[0]), .ram_we_0(we0_o[0]),
    .ram_oe_0(oe0_o[0]), .ram_addr_1(addr1_o[0]), .ram_data_1(data1_i[0]), .ram_cs_1(cs1_o[0]),
    .ram_we_1(we1_o[0]), .ram_oe_1(oe1_o[0]));

  fifo_ctrl #(.ADDR_WIDTH(4), .DEPTH(12), .DATA_WIDTH(16)) u12 (
`ifdef FIFO_ERR_FLAGS_EN
    .overflow(ovf_o[1]), .underflow(unf_o[1]),
`endif
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_req(wr_req), .wr_data(wr_data),
    .wr_ack(wr_ack_o[1]), .rd_req(rd_req), .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]),
    .full(full_o[1]), .empty(empty_o[1]), .count(count_o[1]),
    .ram_addr_0(addr0_o[1]), .ram_data_0(data0_o[1]), .ram_cs_0(cs0_o[1]), .ram_we_0(we0_o[1]),
    .ram_oe_0(oe0_o[1]), .ram_addr_1(addr1_o[1]), .ram_data_1(data1_i[1]), .ram_cs_1(cs1_o[1]),
    .ram_we_1(we1_o[1]), .ram_oe_1(oe1_o[1]));

`ifndef FIFO_ERR_FLAGS_EN
  assign ovf_o[0] = 1'b0;
  assign unf_o[0] = 1'b0;
  assign ovf_o[1] = 1'b0;
  assign unf_o[1] = 1'b0;
`endif

  // External RAM models: synchronous write, level-sensitive read while selected.
  always @(posedge clk) begin
    if (cs0_o[0] && we0_o[0]) mem[0][addr0_o[0]] <= data0_o[0];
    if (cs0_o[1] && we0_o[1]) mem[1][addr0_o[1]] <= data0_o[1];
  end
  assign data1_i[0] = (cs1_o[0] && oe1_o[0]) ? mem[0][addr1_o[0]] : 16'h0000;
  assign data1_i[1] = (cs1_o[1] && oe1_o[1]) ? mem[1][addr1_o[1]] : 16'h0000;

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s[depth%0d]: observed %0h expected %0h", tag, dep[i], obs, exp);
    end
  endtask

  // One clock: drive, check the combinational response, clock, check registered state.
  task automatic step(input logic w, input logic [15:0] wd, input logic r,
                      input logic f, input logic rs);
    @(negedge clk);
    wr_req = w; wr_data = wd; rd_req = r; flush = f; rst_n = rs;
    #1;
    for (int i = 0; i < 2; i++) begin
      bit fm = (mq[i].size() == dep[i]);
      bit em = (mq[i].size() == 0);
      bit wa = rs && w && !f && !fm;
      bit ra = rs && r && !f && !em;
      chk("wr_ack", i, 32'(wr_ack_o[i]), 32'(wa));
      if (primed != 0) begin
        chk("ram_cs_0", i, 32'(cs0_o[i]), 32'(wa));
        chk("ram_we_0", i, 32'(we0_o[i]), 32'(wa));
        chk("ram_oe_0", i, 32'(oe0_o[i]), 32'd0);
        chk("ram_cs_1", i, 32'(cs1_o[i]), 32'(ra));
        chk("ram_oe_1", i, 32'(oe1_o[i]), 32'(ra));
        chk("ram_we_1", i, 32'(we1_o[i]), 32'd0);
        chk("ram_addr_1", i, 32'(addr1_o[i]), 32'(rp[i]));
        if (wa) begin
          chk("ram_addr_0", i, 32'(addr0_o[i]), 32'(wp[i]));
          chk("ram_data_0", i, 32'(data0_o[i]), 32'(wd));
        end
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      bit fm = (mq[i].size() == dep[i]);
      bit em = (mq[i].size() == 0);
      if (!rs) begin
        mq[i].delete(); wp[i] = 0; rp[i] = 0; rdv[i] = 0; rdd[i] = '0; ovf[i] = 0; unf[i] = 0;
      end else if (f) begin
        mq[i].delete(); wp[i] = 0; rp[i] = 0; rdv[i] = 0; ovf[i] = 0; unf[i] = 0;
      end else begin
        rdv[i] = r && !em;
        if (r && !em) begin
          rdd[i] = mq[i].pop_front();
          rp[i] = (rp[i] + 1) % dep[i];
        end
        if (w && !fm) begin
          mq[i].push_back(wd);
          wp[i] = (wp[i] + 1) % dep[i];
        end
        if (w && fm) ovf[i] = 1'b1;
        if (r && em) unf[i] = 1'b1;
      end
    end
    if (!rs) primed = 1;
    #1;
    if (primed != 0) begin
      for (int i = 0; i < 2; i++) begin
        chk("count", i, 32'(count_o[i]), 32'(mq[i].size()));
        chk("full", i, 32'(full_o[i]), 32'(mq[i].size() == dep[i]));
        chk("empty", i, 32'(empty_o[i]), 32'(mq[i].size() == 0));
        chk("rd_valid", i, 32'(rd_valid_o[i]), 32'(rdv[i]));
        chk("rd_data", i, 32'(rd_data_o[i]), 32'(rdd[i]));
`ifdef FIFO_ERR_FLAGS_EN
        chk("overflow", i, 32'(ovf_o[i]), 32'(ovf[i]));
        chk("underflow", i, 32'(unf_o[i]), 32'(unf[i]));
`endif
      end
    end
  endtask

  initial begin
    // Reset with requests and flush asserted: reset must win.
    step(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);

    // Three writes, then three reads with one-cycle latency.
    step(1'b1, 16'h1111, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h2222, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h3333, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    // Fill to 16 and try a 17th write (depth-12 instance saturates earlier).
    for (int k = 0; k < 17; k++) step(1'b1, 16'(16'hA000 + k), 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h5555, 1'b0, 1'b0, 1'b1);

    // Full with simultaneous write and read.
    step(1'b1, 16'h7777, 1'b1, 1'b0, 1'b1);

    // Drain, then simultaneous write and read on empty.
    for (int k = 0; k < 17; k++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'hABCD, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);

    // Thirty write/read pairs to wrap both pointer sets.
    for (int k = 0; k < 30; k++) begin
      step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b1);
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    end

    // Randomised traffic with write-heavy and read-heavy phases, rare flush/reset.
    for (int k = 0; k < 400; k++) begin
      int wp_pct = ((k / 50) % 2 == 0) ? 75 : 25;
      logic w = ($urandom_range(0, 99) < wp_pct);
      logic r = ($urandom_range(0, 99) < (100 - wp_pct));
      logic f = ($urandom_range(0, 39) == 0);
      logic rs = ($urandom_range(0, 79) != 0);
      step(w, 16'($urandom), r, f, rs);
    end

    // count=5 with error flags set, then flush, then reset mid-stream.
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b1, 16'(16'hC000 + k), 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h9999, 1'b1, 1'b1, 1'b1);
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h5678, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h4321, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
